// File: rtl/tb_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_port_pkg
//  Description : Shared constants and replay state encoding for the test-port snoop.
//  Revision    : 1.0 - initial release
// ============================================================================
package tb_port_pkg;

    localparam logic [29:0] c_port_addr = 30'h40;
    localparam logic [31:0] c_begin_sym = 32'h00000932;
    localparam logic [31:0] c_end_sym   = 32'h00000D5D;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } replay_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO; a push while full succeeds only with a same-edge pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == c_depth);
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = pop && !w_empty;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign w_do_push = push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = w_full;
    assign empty = w_empty;
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/test_port_snoop.sv
`default_nettype none
// ============================================================================
//  Module      : test_port_snoop
//  Description : Captures completed CPU stores to the test port and replays each
//                one to the result checker as a single wen pulse plus a low gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module test_port_snoop
    import tb_port_pkg::*;
#(
    parameter logic [29:0] PORT_ADDR  = c_port_addr,
    parameter int          DEPTH      = 8,
    parameter int          GAP_CYCLES = 1,
    parameter logic [31:0] BEGIN_SYM  = c_begin_sym,
    parameter logic [31:0] END_SYM    = c_end_sym
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [29:0]                cpu_addr,
    input  logic [31:0]                cpu_wdata,
    input  logic                       cpu_wen,
    input  logic                       dcache_stall,
    output logic [29:0]                tb_addr,
    output logic [31:0]                tb_data,
    output logic                       tb_wen,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt,
    output logic                       seen_begin,
    output logic                       seen_end
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] c_gap_load = GW'(GAP_CYCLES - 1);

    replay_state_t r_state;
    replay_state_t w_state_nxt;

    logic [GW-1:0] r_gap_cnt;
    logic [GW-1:0] w_gap_nxt;
    logic          r_tb_wen;
    logic          w_tb_wen_nxt;
    logic [29:0]   r_tb_addr;
    logic [29:0]   w_tb_addr_nxt;
    logic [31:0]   r_tb_data;
    logic [31:0]   w_tb_data_nxt;

    logic          r_overflow;
    logic [7:0]    r_drop_cnt;
    logic          r_seen_begin;
    logic          r_seen_end;

    logic          w_accept;
    logic          w_pop;
    logic          w_drop;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [31:0]   w_fifo_rdata;

    // Only the cycle where the stall has cleared completes the store.
    assign w_accept = cpu_wen && !dcache_stall && (cpu_addr == PORT_ADDR);
    assign w_drop   = w_accept && w_fifo_full && !w_pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_accept),
        .wdata (cpu_wdata),
        .pop   (w_pop),
        .rdata (w_fifo_rdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (fifo_count)
    );

    // Empty is decoded from the registered count, so a word pushed on this
    // edge is only seen by the replay logic on the next one.
    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_gap_nxt     = r_gap_cnt;
        w_tb_wen_nxt  = 1'b0;
        w_tb_addr_nxt = '0;
        w_tb_data_nxt = '0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop         = 1'b1;
                    w_tb_wen_nxt  = 1'b1;
                    w_tb_addr_nxt = PORT_ADDR;
                    w_tb_data_nxt = w_fifo_rdata;
                    w_state_nxt   = PULSE;
                end
            end
            PULSE: begin
                w_gap_nxt   = c_gap_load;
                w_state_nxt = GAP;
            end
            GAP: begin
                if (r_gap_cnt == '0) begin
                    if (!w_fifo_empty) begin
                        w_pop         = 1'b1;
                        w_tb_wen_nxt  = 1'b1;
                        w_tb_addr_nxt = PORT_ADDR;
                        w_tb_data_nxt = w_fifo_rdata;
                        w_state_nxt   = PULSE;
                    end else begin
                        w_state_nxt   = IDLE;
                    end
                end else begin
                    w_gap_nxt = r_gap_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_gap_cnt <= '0;
            r_tb_wen  <= 1'b0;
            r_tb_addr <= '0;
            r_tb_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_tb_wen  <= w_tb_wen_nxt;
            r_tb_addr <= w_tb_addr_nxt;
            r_tb_data <= w_tb_data_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow   <= 1'b0;
            r_drop_cnt   <= '0;
            r_seen_begin <= 1'b0;
            r_seen_end   <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
            if (w_accept && cpu_wdata == BEGIN_SYM) begin
                r_seen_begin <= 1'b1;
            end
            if (w_accept && cpu_wdata == END_SYM && r_seen_begin) begin
                r_seen_end <= 1'b1;
            end
        end
    end

    assign tb_wen     = r_tb_wen;
    assign tb_addr    = r_tb_addr;
    assign tb_data    = r_tb_data;
    assign overflow   = r_overflow;
    assign drop_cnt   = r_drop_cnt;
    assign seen_begin = r_seen_begin;
    assign seen_end   = r_seen_end;

endmodule
`default_nettype wire

// File: tb/tb_test_port_snoop.sv
`default_nettype none
// ============================================================================
//  Module      : tb_test_port_snoop
//  Description : Scoreboard bench: stimulus queues expected replay words, a
//                monitor pops them on every tb_wen pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_test_port_snoop;
    import tb_port_pkg::*;

    localparam int DEPTH      = 8;
    localparam int GAP_CYCLES = 1;
    localparam logic [29:0] PA = 30'h40;

    logic        clk;
    logic        rst;
    logic [29:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_wen;
    logic        dcache_stall;
    logic [29:0] tb_addr;
    logic [31:0] tb_data;
    logic        tb_wen;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        seen_begin;
    logic        seen_end;

    int          n_cmp;
    int          n_err;
    logic [31:0] sb[$];

    test_port_snoop #(
        .PORT_ADDR  (PA),
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP_CYCLES),
        .BEGIN_SYM  (32'h00000932),
        .END_SYM    (32'h00000D5D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_wen      (cpu_wen),
        .dcache_stall (dcache_stall),
        .tb_addr      (tb_addr),
        .tb_data      (tb_data),
        .tb_wen       (tb_wen),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .seen_begin   (seen_begin),
        .seen_end     (seen_end)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic wen, input logic [29:0] a, input logic [31:0] d,
                         input logic st);
        @(negedge clk);
        #1;
        cpu_wen      = wen;
        cpu_addr     = a;
        cpu_wdata    = d;
        dcache_stall = st;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((fifo_count != 0 || tb_wen) && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("drain_bound", (i < 200), 1);
        repeat (4) @(negedge clk);
    endtask

    // Monitor: every pulse must match the scoreboard head and respect the gap.
    initial begin
        logic [31:0] e;
        int          low_run;
        bit          seen_pulse;
        low_run    = 0;
        seen_pulse = 0;
        forever begin
            @(negedge clk);
            if (tb_wen === 1'b1) begin
                if (seen_pulse) chk("pulse_gap", (low_run >= GAP_CYCLES), 1);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got data %h expected no pulse (t=%0t)",
                             tb_data, $time);
                end else begin
                    e = sb.pop_front();
                    chk("tb_data", tb_data, e);
                    chk("tb_addr", tb_addr, PA);
                end
                seen_pulse = 1;
                low_run    = 0;
            end else begin
                low_run++;
                chk("idle_data", tb_data, 0);
                chk("idle_addr", tb_addr, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b1;
        cpu_wen      = 1'b0;
        cpu_addr     = '0;
        cpu_wdata    = '0;
        dcache_stall = 1'b0;
        #2 rst = 1'b0;
        #20;
        chk("rst_tb_wen", tb_wen, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_flags", {seen_begin, seen_end}, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: store held across three stall cycles is replayed once
        drive(1, PA, 32'd5, 1);
        drive(1, PA, 32'd5, 1);
        drive(1, PA, 32'd5, 1);
        drive(1, PA, 32'd5, 0);
        chk("t1_stall_count", fifo_count, 0);
        sb.push_back(32'd5);
        drive(0, '0, '0, 0);
        chk("t1_count", fifo_count, 1);
        drain();
        chk("t1_replayed", sb.size(), 0);

        // 2: back-to-back stores stay distinct and ordered
        for (int i = 1; i <= 3; i++) begin
            drive(1, PA, 32'(i), 0);
            sb.push_back(32'(i));
        end
        drive(0, '0, '0, 0);
        drain();
        chk("t2_replayed", sb.size(), 0);

        // 3: wrong address and wen low are ignored
        drive(1, 30'h44, 32'd7, 0);
        drive(0, PA, 32'd8, 0);
        drive(0, '0, '0, 0);
        chk("t3_count", fifo_count, 0);
        repeat (6) @(negedge clk);
        chk("t3_count_later", fifo_count, 0);

        // 4: 17-store burst; pops every other edge, so only word 16 meets a full FIFO
        chk("t4_ovf_before", overflow, 0);
        for (int i = 0; i <= 16; i++) begin
            drive(1, PA, 32'(i), 0);
            if (i < 16) sb.push_back(32'(i));
        end
        drive(0, '0, '0, 0);
        chk("t4_count_full", fifo_count, 8);
        chk("t4_overflow", overflow, 1);
        chk("t4_drop_cnt", drop_cnt, 1);
        drain();
        chk("t4_replayed", sb.size(), 0);
        chk("t4_drop_hold", drop_cnt, 1);

        // 5: END before BEGIN does not count
        drive(1, PA, 32'h00000D5D, 0);
        sb.push_back(32'h00000D5D);
        drive(0, '0, '0, 0);
        chk("t5_end_early", seen_end, 0);
        chk("t5_begin_none", seen_begin, 0);
        drive(1, PA, 32'h00000932, 0);
        sb.push_back(32'h00000932);
        drive(0, '0, '0, 0);
        chk("t5_begin", seen_begin, 1);
        chk("t5_end_still0", seen_end, 0);
        drive(1, PA, 32'h00000D5D, 0);
        sb.push_back(32'h00000D5D);
        drive(0, '0, '0, 0);
        chk("t5_end", seen_end, 1);
        drain();
        chk("t5_replayed", sb.size(), 0);

        // 6: reset during a pulse with four words still queued
        for (int i = 0; i < 8; i++) begin
            drive(1, PA, 32'hA0 + 32'(i), 0);
            sb.push_back(32'hA0 + 32'(i));
        end
        drive(0, '0, '0, 0);
        found = 0;
        for (int j = 0; j < 20 && !found; j++) begin
            if (tb_wen && fifo_count == 4) found = 1;
            else @(negedge clk);
        end
        chk("t6_pulse_with_4", found, 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_wen", tb_wen, 0);
        chk("t6_rst_count", fifo_count, 0);
        chk("t6_rst_data", tb_data, 0);
        chk("t6_rst_flags", {overflow, seen_begin, seen_end}, 0);
        chk("t6_rst_drop", drop_cnt, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_after_count", fifo_count, 0);
        chk("t6_after_wen", tb_wen, 0);

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
